s444_drv: RTL and testbench
===========================

# s444_drv

Stimulus initiator for the s444 controller benchmark. It drives the benchmark's G0 (clear) and G1/G2 request inputs. It samples the benchmark's six outputs as a status word and runs a fixed-length sequence of toggle requests, waiting for a status change after each one. It sits in the test harness between the run controller and the s444 instance, and reports captured responses, a completion count, and a timeout error.

## Interface
- CLR_CYC, 4: cycles G0 is held high after START; legal range 1..255.
- TIMEOUT, 63: last WAIT cycle index before a timeout is declared; legal range 1..255.
- NREQ, 16: requests issued per run; legal range 1..255.

Ports:
- CK  in  1  clock, rising edge.
- RN  in  1  reset, asynchronous, active-low.
- START  in  1  begin a run; sampled only in IDLE.
- STAT  in  6  DUT status {G107,G108,G118,G119,G167,G168}.
- G0  out  1  DUT clear.
- G1  out  1  DUT request line A.
- G2  out  1  DUT request line B.
- BUSY  out  1  run in progress.
- DONE  out  1  one-cycle end-of-run pulse.
- ERR  out  1  sticky timeout flag.
- RSP  out  6  last captured status.
- CNT  out  8  count of requests that got a response.

## Operation
- Reset values (asserted immediately on RN low, even mid-run): state IDLE, G0=1, G1=0, G2=0, BUSY=0, DONE=0, ERR=0, RSP=0, CNT=0, internal counters 0.
- **IDLE:** G0=1, BUSY=0. START=1 moves to CLEAR and, on the same edge, clears ERR, RSP, CNT and the request index.
- **CLEAR:** G0=1, G1=G2=0, BUSY=1. Lasts exactly CLR_CYC cycles, then moves to ISSUE.
- **ISSUE:** one cycle. G0=0. Snapshot the sampled status into SNAP. Toggle G1 if the request index is even, otherwise toggle G2. Go to WAIT with the wait counter at 0.
- **WAIT:** G0=0.
  - Sampled status != SNAP: capture it into RSP, CNT+1, exit.
  - Otherwise, wait counter == TIMEOUT: set ERR; RSP and CNT are unchanged; exit.
  - Otherwise: increment the wait counter.
  - A change and a timeout in the same cycle resolve as a response.
- **Exit from WAIT:** if the request index == NREQ-1, go to FIN. Otherwise increment the index and go to ISSUE.
- **FIN:** one cycle. DONE=1, BUSY=0, G0=1. Then IDLE.
- START outside IDLE is ignored, including START in the FIN cycle.
- CNT saturates at 255; no wrap within a legal configuration.
- BUSY=1 in CLEAR, ISSUE and WAIT only.

## Timing
- START high at edge t: CLEAR from t+1, G0 stays high through t+CLR_CYC, ISSUE at t+CLR_CYC+1.
- G1/G2 toggle is visible the cycle after ISSUE.
- Earliest response capture is the first WAIT cycle; RSP/CNT update on that edge.
- Worst-case request duration is TIMEOUT+2 cycles (ISSUE plus TIMEOUT+1 WAIT cycles).
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- Macro: S444_DRV_STAT_SYNC_EN.
- Defined: STAT passes through a two-flop synchronizer (reset 0) before SNAP capture and comparison. This adds 2 cycles to response detection; the timeout count is unchanged.
- Undefined: STAT is compared directly, with no added latency.

## Test plan
- Reset mid-WAIT: drop RN during request 3 -> same cycle G0=1, G1=G2=0, BUSY=0, CNT=0; after RN rises and with no START, the block stays in IDLE.
- Normal run, CLR_CYC=4, NREQ=4: STAT echo model changes 2 cycles after each toggle -> G1,G2,G1,G2 toggle in order, CNT=4, ERR=0, a single DONE pulse, BUSY low afterwards.
- Timeout, TIMEOUT=5: STAT held constant -> each request spends 6 WAIT cycles, ERR=1, CNT=0, RSP=0, DONE after NREQ requests.
- Tie at boundary: STAT changes exactly in the cycle the wait counter is 5 (TIMEOUT=5) -> counted as a response, CNT+1, ERR unchanged.
- START ignored: START pulses during CLEAR, WAIT and FIN -> no restart; CNT and ERR are not cleared until a START seen in IDLE.
- With S444_DRV_STAT_SYNC_EN defined: the same echo model -> each RSP capture is 2 cycles later than without the macro; final CNT is identical.

Source files
------------

// File: rtl/s444_drv.sv
// s444_drv: stimulus initiator for the s444 controller benchmark.
// Clears the benchmark, issues NREQ alternating G1/G2 toggle requests, and
// waits up to TIMEOUT+1 cycles for the six-bit status word to change after each.
//
// Parameters:
//   CLR_CYC  cycles G0 is held high after START (1..255)
//   TIMEOUT  last wait-cycle index before a timeout is declared (1..255)
//   NREQ     requests issued per run (1..255)
//
// Ports:
//   CK     in   clock, rising edge
//   RN     in   asynchronous active-low reset
//   START  in   begin a run (sampled only in IDLE)
//   STAT   in   [5:0] benchmark status {G107,G108,G118,G119,G167,G168}
//   G0     out  benchmark clear
//   G1     out  request line A
//   G2     out  request line B
//   BUSY   out  run in progress (CLEAR/ISSUE/WAIT)
//   DONE   out  one-cycle end-of-run pulse
//   ERR    out  sticky timeout flag
//   RSP    out  [5:0] last captured status
//   CNT    out  [7:0] requests that got a response (saturating)
//
// Optional feature: define S444_DRV_STAT_SYNC_EN to pass STAT through a
// two-flop synchronizer before it is snapshotted and compared.
module s444_drv #(
  parameter int unsigned CLR_CYC = 4,
  parameter int unsigned TIMEOUT = 63,
  parameter int unsigned NREQ    = 16
) (
  input  logic       CK,
  input  logic       RN,
  input  logic       START,
  input  logic [5:0] STAT,
  output logic       G0,
  output logic       G1,
  output logic       G2,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR,
  output logic [5:0] RSP,
  output logic [7:0] CNT
);

  localparam int unsigned SW = 6;
  localparam int unsigned CW = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_FIN   = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic          g0_q, g0_d;
  logic          g1_q, g1_d;
  logic          g2_q, g2_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [SW-1:0] rsp_q, rsp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] clr_q, clr_d;
  logic [CW-1:0] wait_q, wait_d;
  logic [CW-1:0] idx_q, idx_d;
  logic [SW-1:0] snap_q, snap_d;
  logic [SW-1:0] stat_s;
  logic          exit_wait;

`ifdef S444_DRV_STAT_SYNC_EN
  // Two-flop synchronizer on the status word
  logic [SW-1:0] sync1_q, sync1_d;
  logic [SW-1:0] sync2_q, sync2_d;

  always_comb begin
    sync1_d = STAT;
    sync2_d = sync1_q;
  end

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign stat_s = sync2_q;
`else
  assign stat_s = STAT;
`endif

  // Next-state and registered-output computation
  always_comb begin
    state_d   = state_q;
    g1_d      = g1_q;
    g2_d      = g2_q;
    err_d     = err_q;
    rsp_d     = rsp_q;
    cnt_d     = cnt_q;
    clr_d     = clr_q;
    wait_d    = wait_q;
    idx_d     = idx_q;
    snap_d    = snap_q;
    exit_wait = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d = ST_CLEAR;
          err_d   = 1'b0;
          rsp_d   = '0;
          cnt_d   = '0;
          idx_d   = '0;
          clr_d   = '0;
          g1_d    = 1'b0;
          g2_d    = 1'b0;
        end
      end
      ST_CLEAR: begin
        if (clr_q == CW'(CLR_CYC - 1)) begin
          state_d = ST_ISSUE;
        end else begin
          clr_d = clr_q + CW'(1);
        end
      end
      ST_ISSUE: begin
        snap_d  = stat_s;
        wait_d  = '0;
        state_d = ST_WAIT;
        if (!idx_q[0]) begin
          g1_d = ~g1_q;
        end else begin
          g2_d = ~g2_q;
        end
      end
      ST_WAIT: begin
        // A change seen on the timeout cycle still counts as a response
        if (stat_s != snap_q) begin
          rsp_d     = stat_s;
          exit_wait = 1'b1;
          if (cnt_q != '1) begin
            cnt_d = cnt_q + CW'(1);
          end
        end else if (wait_q == CW'(TIMEOUT)) begin
          err_d     = 1'b1;
          exit_wait = 1'b1;
        end else begin
          wait_d = wait_q + CW'(1);
        end
        if (exit_wait) begin
          if (idx_q == CW'(NREQ - 1)) begin
            state_d = ST_FIN;
          end else begin
            idx_d   = idx_q + CW'(1);
            state_d = ST_ISSUE;
          end
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Registered outputs follow the state being entered
    g0_d   = (state_d == ST_IDLE) || (state_d == ST_CLEAR) || (state_d == ST_FIN);
    busy_d = (state_d == ST_CLEAR) || (state_d == ST_ISSUE) || (state_d == ST_WAIT);
    done_d = (state_d == ST_FIN);
  end

  // State and output registers
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state_q <= ST_IDLE;
      g0_q    <= 1'b1;
      g1_q    <= 1'b0;
      g2_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rsp_q   <= '0;
      cnt_q   <= '0;
      clr_q   <= '0;
      wait_q  <= '0;
      idx_q   <= '0;
      snap_q  <= '0;
    end else begin
      state_q <= state_d;
      g0_q    <= g0_d;
      g1_q    <= g1_d;
      g2_q    <= g2_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rsp_q   <= rsp_d;
      cnt_q   <= cnt_d;
      clr_q   <= clr_d;
      wait_q  <= wait_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
    end
  end

  assign G0   = g0_q;
  assign G1   = g1_q;
  assign G2   = g2_q;
  assign BUSY = busy_q;
  assign DONE = done_q;
  assign ERR  = err_q;
  assign RSP  = rsp_q;
  assign CNT  = cnt_q;

endmodule

// File: tb/tb_s444_drv.sv
// tb_s444_drv: directed bench for s444_drv with an echo model of the s444
// status response and a queue of expected toggle/capture events.
module tb_s444_drv;

  localparam int unsigned CLR = 4;
  localparam int unsigned TMO = 5;
  localparam int unsigned NRQ = 4;
`ifdef S444_DRV_STAT_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif
  localparam int NO_ERR = 1 << 30;

  logic       CK = 1'b0;
  logic       RN = 1'b0;
  logic       START = 1'b0;
  logic [5:0] STAT;
  logic       G0, G1, G2, BUSY, DONE, ERR;
  logic [5:0] RSP;
  logic [7:0] CNT;

  // Echo model: status mirrors {G1,G2} two cycles later
  logic       echo_en = 1'b1;
  logic [5:0] stat_force = '0;
  logic [1:0] p1 = '0;
  logic [1:0] p2 = '0;

  assign STAT = echo_en ? {4'b0000, p2} : stat_force;

  always @(posedge CK) begin
    p1 <= {G1, G2};
    p2 <= p1;
  end

  always #5 CK = ~CK;

  s444_drv #(.CLR_CYC(CLR), .TIMEOUT(TMO), .NREQ(NRQ)) dut (
    .CK(CK), .RN(RN), .START(START), .STAT(STAT),
    .G0(G0), .G1(G1), .G2(G2), .BUSY(BUSY), .DONE(DONE), .ERR(ERR),
    .RSP(RSP), .CNT(CNT)
  );

  typedef struct { int k; logic g1; logic g2; } tog_t;
  typedef struct { int k; logic [5:0] rsp; logic [7:0] cnt; } cap_t;
  typedef struct { int k; logic [5:0] val; } sch_t;

  tog_t tog_q[$];
  cap_t cap_q[$];
  sch_t sch_q[$];
  int   start_q[$];

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Queue expected events for one run; p is cycles per request
  task automatic push_reqs(input int p, input bit echo_rsp, input bit tie);
    logic g1m, g2m;
    int   iss;
    g1m = 1'b0;
    g2m = 1'b0;
    for (int i = 0; i < int'(NRQ); i++) begin
      iss = int'(CLR) + i * p;
      if (i % 2 == 0) g1m = ~g1m;
      else            g2m = ~g2m;
      tog_q.push_back('{iss + 1, g1m, g2m});
      if (echo_rsp)
        cap_q.push_back('{iss + p, {4'b0000, g1m, g2m}, 8'(i + 1)});
      if (tie) begin
        sch_q.push_back('{iss + int'(TMO) + 1 - LAT, 6'(i + 1)});
        cap_q.push_back('{iss + int'(TMO) + 2, 6'(i + 1), 8'(i + 1)});
      end
    end
  endtask

  // Start a run and check every cycle up to a few cycles past DONE
  task automatic run(input int done_k, input int err_k);
    logic [1:0] pg;
    logic [7:0] pc;
    tog_t t;
    cap_t c;
    pg = '0;
    pc = '0;
    @(negedge CK);
    START = 1'b1;
    @(posedge CK);
    #1;
    for (int k = 0; k <= done_k + 3; k++) begin
      if (k > 0) begin
        @(posedge CK);
        #1;
      end
      START = 1'b0;
      if (start_q.size() > 0 && start_q[0] == k) begin
        START = 1'b1;
        void'(start_q.pop_front());
      end
      if (sch_q.size() > 0 && sch_q[0].k == k) begin
        stat_force = sch_q[0].val;
        void'(sch_q.pop_front());
      end
      chk("busy", BUSY, k < done_k);
      chk("done", DONE, k == done_k);
      chk("g0", G0, (k < int'(CLR)) || (k >= done_k));
      chk("err", ERR, k >= err_k);
      if (k == 0) begin
        chk("cnt_clr", CNT, 0);
        chk("rsp_clr", RSP, 0);
        chk("g12_clr", {G1, G2}, 0);
      end else begin
        if ({G1, G2} !== pg) begin
          if (tog_q.size() == 0) begin
            chk("tog_extra", {G1, G2}, pg);
          end else begin
            t = tog_q.pop_front();
            chk("tog_cycle", k, t.k);
            chk("tog_val", {G1, G2}, {t.g1, t.g2});
          end
        end
        if (CNT !== pc) begin
          if (cap_q.size() == 0) begin
            chk("cap_extra", CNT, pc);
          end else begin
            c = cap_q.pop_front();
            chk("cap_cycle", k, c.k);
            chk("cap_rsp", RSP, c.rsp);
            chk("cap_cnt", CNT, c.cnt);
          end
        end
      end
      pg = {G1, G2};
      pc = CNT;
    end
    START = 1'b0;
    chk("tog_left", tog_q.size(), 0);
    chk("cap_left", cap_q.size(), 0);
    tog_q.delete();
    cap_q.delete();
    sch_q.delete();
    start_q.delete();
  endtask

  initial begin
    int iss3;

    // Reset state
    RN = 1'b0;
    repeat (3) @(posedge CK);
    #1;
    chk("rst_g0", G0, 1);
    chk("rst_g1", G1, 0);
    chk("rst_g2", G2, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_err", ERR, 0);
    chk("rst_rsp", RSP, 0);
    chk("rst_cnt", CNT, 0);
    @(negedge CK);
    RN = 1'b1;
    repeat (3) @(posedge CK);

    // Normal run with echo; START pulses in CLEAR, WAIT and FIN are ignored
    echo_en = 1'b1;
    push_reqs(4 + LAT, 1'b1, 1'b0);
    start_q.push_back(1);
    start_q.push_back(6);
    start_q.push_back(int'(CLR) + int'(NRQ) * (4 + LAT));
    run(int'(CLR) + int'(NRQ) * (4 + LAT), NO_ERR);
    stat_force = 6'h2A;
    for (int i = 0; i < 3; i++) begin
      @(posedge CK);
      #1;
      chk("idle1_cnt", CNT, 4);
      chk("idle1_err", ERR, 0);
      chk("idle1_busy", BUSY, 0);
    end

    // Timeout on every request, status held constant
    echo_en = 1'b0;
    push_reqs(int'(TMO) + 2, 1'b0, 1'b0);
    start_q.push_back(2);
    start_q.push_back(int'(CLR) + int'(NRQ) * (int'(TMO) + 2));
    run(int'(CLR) + int'(NRQ) * (int'(TMO) + 2), int'(CLR) + int'(TMO) + 2);
    stat_force = 6'h00;
    for (int i = 0; i < 3; i++) begin
      @(posedge CK);
      #1;
      chk("idle2_cnt", CNT, 0);
      chk("idle2_rsp", RSP, 0);
      chk("idle2_err", ERR, 1);
    end

    // Status change on the last wait cycle counts as a response
    push_reqs(int'(TMO) + 2, 1'b0, 1'b1);
    run(int'(CLR) + int'(NRQ) * (int'(TMO) + 2), NO_ERR);

    // Reset in the middle of the fourth request's wait
    echo_en = 1'b1;
    repeat (3) @(posedge CK);
    iss3 = int'(CLR) + 3 * (4 + LAT);
    @(negedge CK);
    START = 1'b1;
    @(posedge CK);
    #1;
    START = 1'b0;
    repeat (iss3 + 2) @(posedge CK);
    #1;
    chk("pre_rst_busy", BUSY, 1);
    chk("pre_rst_cnt", CNT, 3);
    RN = 1'b0;
    #1;
    chk("mid_rst_g0", G0, 1);
    chk("mid_rst_g12", {G1, G2}, 0);
    chk("mid_rst_busy", BUSY, 0);
    chk("mid_rst_cnt", CNT, 0);
    repeat (2) @(posedge CK);
    @(negedge CK);
    RN = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge CK);
      #1;
      chk("post_rst_busy", BUSY, 0);
      chk("post_rst_g0", G0, 1);
      chk("post_rst_done", DONE, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
